// File: rtl/tq_size_align_delay.sv
// Transform-size dependent latency aligner. Each beat carries its size tag down
// a shared pipe and is emitted from the stage that matches its size's delay.

module tq_size_align_lane #(
  parameter int DW      = 28,
  parameter int MAX_DLY = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ld,
  input  logic [DW-1:0]      din,
  input  logic [MAX_DLY:0]   sel,
  output logic [DW-1:0]      dout
);
  logic [MAX_DLY:1][DW-1:0] pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe <= '0;
    end else begin
      if (ld) pipe[1] <= din;
      for (int s = 2; s <= MAX_DLY; s++) pipe[s] <= pipe[s-1];
    end
  end

  // sel is one-hot or empty, so an AND-OR mux is enough; sel[0] is the bypass
  always_comb begin
    dout = {DW{sel[0]}} & din;
    for (int s = 1; s <= MAX_DLY; s++) dout = dout | ({DW{sel[s]}} & pipe[s]);
  end
endmodule

module tq_size_align_delay #(
  parameter int LANES   = 32,
  parameter int DW      = 28,
  parameter int MAX_DLY = 2,
  parameter int DLY_4   = 0,
  parameter int DLY_8   = 1,
  parameter int DLY_16  = 2,
  parameter int DLY_32  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_flush,
  input  logic                  i_dt_vld,
  output logic                  o_rdy,
  input  logic [1:0]            i_transize,
  input  logic [LANES*DW-1:0]   i_data,
  output logic                  o_dt_vld,
  output logic [1:0]            o_transize,
  output logic [LANES*DW-1:0]   o_data
);
  function automatic int dly_of(input logic [1:0] t);
    case (t)
      2'd0:    return DLY_4;
      2'd1:    return DLY_8;
      2'd2:    return DLY_16;
      default: return DLY_32;
    endcase
  endfunction

  logic                   acc;
  logic [MAX_DLY:1]       vld_pipe;
  logic [MAX_DLY:1][1:0]  tag_pipe;
  logic [MAX_DLY:0]       sel;

  assign acc = i_dt_vld & o_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
    end else begin
      vld_pipe[1] <= acc;
      if (acc) tag_pipe[1] <= i_transize;
      for (int s = 2; s <= MAX_DLY; s++) begin
        vld_pipe[s] <= vld_pipe[s-1] & ~i_flush;
        tag_pipe[s] <= tag_pipe[s-1];
      end
    end
  end

  // Emitter select: bypass for zero-delay beats, else the stage equal to its delay
  always_comb begin
    sel    = '0;
    sel[0] = acc && (dly_of(i_transize) == 0);
    for (int s = 1; s <= MAX_DLY; s++)
      sel[s] = vld_pipe[s] && !i_flush && (dly_of(tag_pipe[s]) == s);
  end

  assign o_dt_vld = |sel;

  always_comb begin
    o_transize = sel[0] ? i_transize : 2'd0;
    for (int s = 1; s <= MAX_DLY; s++)
      if (sel[s]) o_transize = o_transize | tag_pipe[s];
  end

  // A live beat whose remaining delay is >= the new beat's delay would either
  // collide with it (equal) or be overtaken by it (greater), so hold the input.
  always_comb begin
    int d_in;
    int d_s;
    d_in  = dly_of(i_transize);
    o_rdy = ~i_flush;
    for (int s = 1; s <= MAX_DLY; s++) begin
      d_s = dly_of(tag_pipe[s]);
      if (vld_pipe[s] && (d_s >= s) && (d_s >= s + d_in)) o_rdy = 1'b0;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    tq_size_align_lane #(.DW(DW), .MAX_DLY(MAX_DLY)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .ld    (acc),
      .din   (i_data[k*DW +: DW]),
      .sel   (sel),
      .dout  (o_data[k*DW +: DW])
    );
  end
endmodule

// File: tb/tb_tq_size_align_delay.sv
// Directed and scoreboard bench for tq_size_align_delay: default build plus a
// LANES=4/DW=16/MAX_DLY=4 build with delays 1..4.

module tb_tq_size_align_delay;
  localparam int L  = 32;
  localparam int W  = 28;
  localparam int PL = 4;
  localparam int PW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic flush, vld, rdy, ovld;
  logic [1:0] tsz, otsz;
  logic [L*W-1:0] din, dout;

  logic p_flush, p_vld, p_rdy, p_ovld;
  logic [1:0] p_tsz, p_otsz;
  logic [PL*PW-1:0] p_din, p_dout;

  int checks = 0;
  int errors = 0;

  tq_size_align_delay u_dut (
    .clk(clk), .rst_n(rst_n), .i_flush(flush), .i_dt_vld(vld), .o_rdy(rdy),
    .i_transize(tsz), .i_data(din), .o_dt_vld(ovld), .o_transize(otsz), .o_data(dout)
  );

  tq_size_align_delay #(
    .LANES(PL), .DW(PW), .MAX_DLY(4), .DLY_4(1), .DLY_8(2), .DLY_16(3), .DLY_32(4)
  ) u_dut_p (
    .clk(clk), .rst_n(rst_n), .i_flush(p_flush), .i_dt_vld(p_vld), .o_rdy(p_rdy),
    .i_transize(p_tsz), .i_data(p_din), .o_dt_vld(p_ovld), .o_transize(p_otsz), .o_data(p_dout)
  );

  function automatic logic [L*W-1:0] pat(input int i);
    logic [L*W-1:0] v;
    for (int k = 0; k < L; k++) v[k*W +: W] = W'(i*32 + k);
    return v;
  endfunction

  function automatic logic [PL*PW-1:0] pat_p(input int i);
    logic [PL*PW-1:0] v;
    for (int k = 0; k < PL; k++) v[k*PW +: PW] = PW'(16'hC000 + i*4 + k);
    return v;
  endfunction

  // expected default-build delays
  function automatic int dexp(input logic [1:0] t);
    case (t)
      2'd0:    return 0;
      2'd1:    return 1;
      default: return 2;
    endcase
  endfunction

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; vld = 1'b1; tsz = 2'd1; din = pat(5);
    cyc(); #1;
    checks++;
    if (ovld !== 1'b0 || otsz !== 2'd0 || dout !== '0 || rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_outputs: got vld=%b tsz=%0d rdy=%b data[63:0]=%h, want vld=0 tsz=0 rdy=1 data=0",
               ovld, otsz, rdy, dout[63:0]);
    end
    cyc(); rst_n = 1'b1; #1;
    checks++;
    if (ovld !== 1'b0) begin errors++; $display("FAIL reset_release_early: got vld=%b want 0", ovld); end
    cyc(); vld = 1'b0; #1;
    checks++;
    if (ovld !== 1'b1 || otsz !== 2'd1 || dout !== pat(5)) begin
      errors++;
      $display("FAIL reset_first_8x8: got vld=%b tsz=%0d data[63:0]=%h, want vld=1 tsz=1 data[63:0]=%h",
               ovld, otsz, dout[63:0], pat(5) & 64'hFFFF_FFFF_FFFF_FFFF);
    end
    cyc(); #1;
    checks++;
    if (ovld !== 1'b0) begin errors++; $display("FAIL reset_after: got vld=%b want 0", ovld); end
  endtask

  task automatic test_size(input logic [1:0] tag, input int d, input int n);
    int base;
    base = 100 * (tag + 1);
    for (int c = 0; c <= n + d; c++) begin
      cyc(); vld = (c < n); tsz = tag; din = pat(base + c); #1;
      if (c < n) begin
        checks++;
        if (rdy !== 1'b1) begin errors++; $display("FAIL size%0d_rdy c=%0d: got %b want 1", tag, c, rdy); end
      end
      checks++;
      if (c >= d && c < n + d) begin
        if (ovld !== 1'b1 || otsz !== tag || dout !== pat(base + c - d)) begin
          errors++;
          $display("FAIL size%0d_out c=%0d: got vld=%b tsz=%0d data[63:0]=%h, want vld=1 tsz=%0d beat %0d",
                   tag, c, ovld, otsz, dout[63:0], tag, c - d);
        end
      end else if (ovld !== 1'b0) begin
        errors++; $display("FAIL size%0d_idle c=%0d: got vld=%b want 0", tag, c, ovld);
      end
    end
    vld = 1'b0;
  endtask

  // 32x32 then 4x4: rdy low two cycles, 4x4 accepted/bypassed on the third
  task automatic test_down_switch();
    logic        e_rdy [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic        e_vld [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [1:0]  e_tsz [4] = '{2'd0, 2'd0, 2'd3, 2'd0};
    int          e_pat [4] = '{0, 0, 600, 601};
    for (int c = 0; c < 5; c++) begin
      cyc();
      vld = (c < 4); tsz = (c == 0) ? 2'd3 : 2'd0; din = (c == 0) ? pat(600) : pat(601);
      #1;
      checks++;
      if (c == 4) begin
        if (ovld !== 1'b0) begin errors++; $display("FAIL down_idle: got vld=%b want 0", ovld); end
      end else if (rdy !== e_rdy[c] || ovld !== e_vld[c] ||
                   (e_vld[c] && (otsz !== e_tsz[c] || dout !== pat(e_pat[c])))) begin
        errors++;
        $display("FAIL down_switch t+%0d: got rdy=%b vld=%b tsz=%0d, want rdy=%b vld=%b tsz=%0d",
                 c, rdy, ovld, otsz, e_rdy[c], e_vld[c], e_tsz[c]);
      end
      if (c == 2) vld = 1'b1;
    end
    vld = 1'b0;
  endtask

  // 4x4 -> 32x32 x2 (no stall), then 32x32 -> 8x8 (one stall cycle)
  task automatic test_up_switch();
    logic [1:0] i_tag [9] = '{2'd0, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 2'd3, 2'd1, 2'd1};
    logic       i_vld [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    int         i_pat [9] = '{700, 701, 702, 0, 0, 0, 703, 704, 704};
    logic       e_rdy [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic       e_vld [9] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    int         e_pat [9] = '{700, 0, 0, 701, 702, 0, 0, 0, 703};
    logic [1:0] e_tsz [9] = '{2'd0, 2'd0, 2'd0, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 2'd3};
    for (int c = 0; c < 11; c++) begin
      cyc();
      if (c < 9) begin vld = i_vld[c]; tsz = i_tag[c]; din = pat(i_pat[c]); end
      else vld = 1'b0;
      #1;
      checks++;
      if (c < 9) begin
        if ((i_vld[c] && rdy !== e_rdy[c]) || ovld !== e_vld[c] ||
            (e_vld[c] && (otsz !== e_tsz[c] || dout !== pat(e_pat[c])))) begin
          errors++;
          $display("FAIL up_switch c=%0d: got rdy=%b vld=%b tsz=%0d data[63:0]=%h, want rdy=%b vld=%b tsz=%0d",
                   c, rdy, ovld, otsz, dout[63:0], e_rdy[c], e_vld[c], e_tsz[c]);
        end
      end else if (ovld !== (c == 9) || (c == 9 && (otsz !== 2'd1 || dout !== pat(704)))) begin
        errors++;
        $display("FAIL up_switch_tail c=%0d: got vld=%b tsz=%0d, want vld=%b tsz=1", c, ovld, otsz, c == 9);
      end
    end
  endtask

  task automatic test_flush();
    cyc(); vld = 1'b1; tsz = 2'd2; din = pat(800); #1;
    cyc(); din = pat(801); #1;
    cyc(); flush = 1'b1; tsz = 2'd0; din = pat(802); #1;
    checks++;
    if (rdy !== 1'b0 || ovld !== 1'b0 || dout !== '0) begin
      errors++;
      $display("FAIL flush_cycle: got rdy=%b vld=%b data[63:0]=%h, want rdy=0 vld=0 data=0", rdy, ovld, dout[63:0]);
    end
    cyc(); flush = 1'b0; #1;
    checks++;
    if (ovld !== 1'b1 || otsz !== 2'd0 || dout !== pat(802)) begin
      errors++;
      $display("FAIL flush_next: got vld=%b tsz=%0d data[63:0]=%h, want held 4x4 beat only", ovld, otsz, dout[63:0]);
    end
    cyc(); vld = 1'b0; #1;
    checks++;
    if (ovld !== 1'b0) begin errors++; $display("FAIL flush_dead: got vld=%b want 0", ovld); end
    cyc(); vld = 1'b1; tsz = 2'd1; din = pat(803); #1;
    checks++;
    if (rdy !== 1'b1 || ovld !== 1'b0) begin
      errors++; $display("FAIL flush_resume: got rdy=%b vld=%b want rdy=1 vld=0", rdy, ovld);
    end
    cyc(); vld = 1'b0; #1;
    checks++;
    if (ovld !== 1'b1 || otsz !== 2'd1 || dout !== pat(803)) begin
      errors++; $display("FAIL flush_latency: got vld=%b tsz=%0d want vld=1 tsz=1", ovld, otsz);
    end
  endtask

  typedef struct {
    logic [1:0]     tag;
    logic [L*W-1:0] data;
    int             due;
  } sb_t;

  task automatic test_random(input int n);
    sb_t q[$];
    sb_t e;
    int  sent, cyc_n;
    logic pending;
    sent = 0; cyc_n = 0; pending = 1'b0;
    while ((sent < n || q.size() > 0) && cyc_n < 20000) begin
      cyc();
      if (!pending && sent < n && $urandom_range(0, 9) < 7) begin
        pending = 1'b1;
        tsz = 2'($urandom_range(0, 3));
        for (int k = 0; k < L; k++) din[k*W +: W] = W'($urandom);
      end
      vld = pending;
      #1;
      if (vld && rdy) begin
        e.tag = tsz; e.data = din; e.due = cyc_n + dexp(tsz);
        q.push_back(e);
        pending = 1'b0; sent++;
      end
      if (ovld) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rand_spurious cyc=%0d: got vld=1 with no beat outstanding", cyc_n);
        end else begin
          e = q.pop_front();
          if (otsz !== e.tag || dout !== e.data || cyc_n != e.due) begin
            errors++;
            $display("FAIL rand_order cyc=%0d: got tsz=%0d data[63:0]=%h, want tsz=%0d data[63:0]=%h due=%0d",
                     cyc_n, otsz, dout[63:0], e.tag, e.data[63:0], e.due);
          end
        end
      end
      if (q.size() > 0 && q[0].due <= cyc_n) begin
        checks++; errors++;
        $display("FAIL rand_missed cyc=%0d: got no emission, want tsz=%0d due=%0d", cyc_n, q[0].tag, q[0].due);
        void'(q.pop_front());
      end
      cyc_n++;
    end
    vld = 1'b0;
    checks++;
    if (sent != n || q.size() != 0) begin
      errors++; $display("FAIL rand_timeout: got sent=%0d pending_out=%0d, want sent=%0d pending_out=0", sent, q.size(), n);
    end
  endtask

  task automatic test_param_size(input logic [1:0] tag, input int n);
    int d;
    d = tag + 1;
    for (int c = 0; c <= n + d; c++) begin
      cyc(); p_vld = (c < n); p_tsz = tag; p_din = pat_p(40 * tag + c); #1;
      if (c < n) begin
        checks++;
        if (p_rdy !== 1'b1) begin errors++; $display("FAIL p_size%0d_rdy c=%0d: got %b want 1", tag, c, p_rdy); end
      end
      checks++;
      if (c >= d && c < n + d) begin
        if (p_ovld !== 1'b1 || p_otsz !== tag || p_dout !== pat_p(40 * tag + c - d)) begin
          errors++;
          $display("FAIL p_size%0d_out c=%0d: got vld=%b tsz=%0d data=%h, want vld=1 data=%h",
                   tag, c, p_ovld, p_otsz, p_dout, pat_p(40 * tag + c - d));
        end
      end else if (p_ovld !== 1'b0) begin
        errors++; $display("FAIL p_size%0d_idle c=%0d: got vld=%b want 0", tag, c, p_ovld);
      end
    end
    p_vld = 1'b0;
  endtask

  task automatic test_param_hazard();
    logic [15:0] top;
    cyc(); p_vld = 1'b1; p_tsz = 2'd3; p_din = pat_p(200); #1;
    cyc(); p_tsz = 2'd0; p_din = pat_p(201); #1;
    for (int c = 1; c < 4; c++) begin
      checks++;
      if (p_rdy !== 1'b0 || p_ovld !== 1'b0) begin
        errors++; $display("FAIL p_hazard_stall t+%0d: got rdy=%b vld=%b want rdy=0 vld=0", c, p_rdy, p_ovld);
      end
      if (c < 3) begin cyc(); #1; end
    end
    cyc(); #1;
    top = p_dout[63:48];
    checks++;
    if (p_rdy !== 1'b1 || p_ovld !== 1'b1 || p_otsz !== 2'd3 || top !== 16'hC323) begin
      errors++;
      $display("FAIL p_hazard_accept: got rdy=%b vld=%b tsz=%0d top=%h, want rdy=1 vld=1 tsz=3 top=c323",
               p_rdy, p_ovld, p_otsz, top);
    end
    cyc(); p_vld = 1'b0; #1;
    checks++;
    if (p_ovld !== 1'b1 || p_otsz !== 2'd0 || p_dout !== 64'hC327_C326_C325_C324) begin
      errors++; $display("FAIL p_hazard_second: got vld=%b tsz=%0d data=%h want vld=1 tsz=0 data=c327c326c325c324",
                         p_ovld, p_otsz, p_dout);
    end
    cyc(); #1;
    checks++;
    if (p_ovld !== 1'b0) begin errors++; $display("FAIL p_hazard_idle: got vld=%b want 0", p_ovld); end
  endtask

  initial begin
    p_flush = 1'b0; p_vld = 1'b0; p_tsz = 2'd0; p_din = '0;
    test_reset();
    test_size(2'd0, 0, 100);
    test_size(2'd1, 1, 100);
    test_size(2'd2, 2, 100);
    test_size(2'd3, 2, 100);
    test_down_switch();
    test_up_switch();
    test_flush();
    test_random(2000);
    for (int t = 0; t < 4; t++) test_param_size(2'(t), 20);
    test_param_hazard();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
